axis_master_fifo: RTL and testbench
===================================

Name: axis_master_fifo

Overview:
Parametrised successor to axis_master: a synchronous FIFO-buffered AXI4-Stream master.
- Accepts words from an internal producer with a proper valid/ready handshake.
- Drives M_AXIS with TKEEP/TSTRB, fill-level and packet counters, and a sticky overflow flag for producers that ignore ready.
- Sits between compute-core output (e.g. BNN result stream) and DMA S2MM.

Parameters:
C_M_AXIS_TDATA_WIDTH, 32, data width in bits; multiple of 8, 8..512.
FIFO_DEPTH, 16, entries; power of 2, >=2.
PKT_CNT_WIDTH, 16, width of pkt_count; wraps modulo 2^PKT_CNT_WIDTH.

Ports:
M_AXIS_ACLK  in  1  clock; all logic rising-edge.
M_AXIS_ARESET  in  1  synchronous, active-high reset.
TDATA_in  in  C_M_AXIS_TDATA_WIDTH  upstream data.
TKEEP_in  in  C_M_AXIS_TDATA_WIDTH/8  upstream byte enables.
TVALID_in  in  1  upstream valid.
TLAST_in  in  1  upstream end of packet.
TREADY_out  out  1  upstream ready (= FIFO not full).
M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data.
M_AXIS_TKEEP  out  C_M_AXIS_TDATA_WIDTH/8  byte keep.
M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte strobe, identical to TKEEP.
M_AXIS_TVALID  out  1  stream valid.
M_AXIS_TLAST  out  1  stream last.
M_AXIS_TREADY  in  1  downstream ready.
fill_level  out  $clog2(FIFO_DEPTH)+1  entries currently stored.
pkt_count  out  PKT_CNT_WIDTH  packets fully sent (TLAST handshakes).
overflow  out  1  sticky: TVALID_in high while TREADY_out low.
clear_stats  in  1  synchronous clear of pkt_count and overflow.

Behaviour:
- Reset (synchronous, active-high): pointers cleared; fill_level=0; pkt_count=0; overflow=0; M_AXIS_TVALID=0; M_AXIS_TLAST=0; M_AXIS_TDATA/TKEEP/TSTRB=0; TREADY_out=0 during reset, 1 from the first cycle after.
- Reset asserted mid-packet discards all stored words. No partial packet is emitted after reset.
- Push: TVALID_in && TREADY_out at a clock edge. Stores {TDATA_in, TKEEP_in, TLAST_in}.
- Pop: M_AXIS_TVALID && M_AXIS_TREADY at a clock edge.
- First-word fall-through with registered output: a word pushed at edge N into an empty FIFO shows M_AXIS_TVALID=1 after edge N. Write-to-valid latency is 1 cycle.
- AXIS rule: once M_AXIS_TVALID=1, TDATA/TKEEP/TLAST stay stable until the pop. TVALID never depends combinationally on TREADY.
- Throughput: 1 word/cycle sustained when both sides are continuously valid/ready.
- TREADY_out = (fill_level != FIFO_DEPTH), registered-equivalent. It does not depend on M_AXIS_TREADY in the same cycle.
- Full: push is blocked. A simultaneous pop frees one slot, and TREADY_out=1 the next cycle.
- Empty: M_AXIS_TVALID=0. Simultaneous push and pop on one stored word keeps fill_level unchanged.
- Simultaneous push+pop at any non-full level: fill_level unchanged, data order preserved.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH)+1 bits, using the MSB for full/empty disambiguation. Wrap at FIFO_DEPTH is seamless.
- overflow: set on any cycle with TVALID_in=1 && TREADY_out=0. The dropped word is not stored. Cleared only by reset or clear_stats; set wins over clear_stats in the same cycle.
- pkt_count: +1 on pop with M_AXIS_TLAST=1; wraps to 0. clear_stats zeroes it; a concurrent TLAST pop yields 1.
- TKEEP_in is passed through unmodified. No byte compaction.

Optional Feature:
AXIS_MASTER_PKT_MODE_EN
- Defined: store-and-forward mode.
  - M_AXIS_TVALID is held 0 until at least one complete packet (its TLAST word) is stored.
  - An internal complete-packet counter increments on TLAST push and decrements on TLAST pop.
  - Deadlock escape: if the FIFO is full with zero complete packets, output is released in cut-through until that packet's TLAST pops.
- Undefined: pure cut-through as above; the counter logic is absent.

Decomposition:
- Package axis_pkg: AXIS beat struct typedef {data, keep, last} parametrised via localparams, KEEP_W = C_M_AXIS_TDATA_WIDTH/8, and a clog2-based PTR_W helper.
- One sub-module, axis_sync_fifo: storage array, pointers, full/empty, fill_level, FWFT output register.
- Top level holds the handshake, stats and the PKT_MODE gating.

Test Plan:
1. Reset for 2 cycles, then push 0..31 (TLAST on 31) with M_AXIS_TREADY=1 -> 32 beats out in order, first beat 1 cycle after first push, TLAST on data 31, pkt_count=1, overflow=0.
2. M_AXIS_TREADY=0, push 20 words, FIFO_DEPTH=16 -> TREADY_out=0 after 16 pushes, fill_level=16, overflow=1; release ready -> exactly data 0..15 emerge.
3. Random M_AXIS_TREADY toggling with continuous input over 1000 words -> scoreboard match, TDATA stable while TVALID && !TREADY, fill_level never exceeds 16.
4. Assert M_AXIS_ARESET mid-packet with fill_level=5 -> next cycle TVALID=0, fill_level=0, pkt_count=0; a new packet 0xA..0xC is output cleanly.
5. clear_stats coincident with a TLAST pop at pkt_count=7 -> pkt_count=1.
6. PKT_MODE_EN: push a 4-word packet slowly -> TVALID stays 0 until the 4th word is stored; then push a 20-word packet with no TLAST into depth 16 -> cut-through release at full, no deadlock.

Source files
------------

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AXI4-Stream beat type, width constants and pointer-width helpers
//
// Purpose : common declarations for axis_master_fifo and axis_sync_fifo.
//           axis_beat_t is the beat layout {data, keep, last} at the default
//           32-bit data width; parametrised modules build the same layout
//           locally from their own widths using keep_w()/ptr_w().
// Ports   : none (package).
package axis_pkg;

    localparam int DEFAULT_TDATA_W = 32;
    localparam int KEEP_W          = DEFAULT_TDATA_W / 8;

    typedef struct packed {
        logic [DEFAULT_TDATA_W-1:0] data;
        logic [KEEP_W-1:0]          keep;
        logic                       last;
    } axis_beat_t;

    // Pointer width: one extra MSB beyond the address bits so that full and
    // empty can be told apart when the address bits are equal.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - synchronous first-word-fall-through FIFO with registered head word
//
// Purpose : storage array, read/write pointers, full/empty, fill level and a
//           registered output word. A word written into an empty FIFO is
//           visible on out_data/out_valid right after the writing edge.
// Ports   : clk        - rising-edge clock
//           rst        - synchronous active-high reset
//           in_data    - word to store
//           in_valid   - producer offers in_data
//           in_ready   - FIFO can accept (not full, not in reset)
//           out_data   - head word (registered, held stable while out_valid)
//           out_valid  - head word present (registered)
//           out_ready  - consumer takes the head word
//           fill_level - words currently stored
module axis_sync_fifo
    import axis_pkg::*;
#(
    parameter int DATA_W = 37,
    parameter int DEPTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ptr_w(DEPTH)-1:0] fill_level
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_nxt;
    logic [PW-1:0]     rd_nxt;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] head_nxt;
    logic              valid_q;
    logic              full;
    logic              push;
    logic              pop;

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = !full && !rst;
    assign fill_level = wr_ptr - rd_ptr;
    assign out_data   = head_q;
    assign out_valid  = valid_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = valid_q && out_ready;
        wr_nxt   = wr_ptr + PW'(push);
        rd_nxt   = rd_ptr + PW'(pop);
        head_nxt = head_q;
        if (wr_nxt != rd_nxt) begin
            // The next head is the word being written this very edge when the
            // read pointer lands on the current write slot; otherwise it is
            // already in the array.
            if (push && (rd_nxt == wr_ptr)) begin
                head_nxt = in_data;
            end else begin
                head_nxt = mem[rd_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_ptr  <= wr_nxt;
            rd_ptr  <= rd_nxt;
            valid_q <= (wr_nxt != rd_nxt);
            head_q  <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: rtl/axis_master_fifo.sv
// rtl/axis_master_fifo.sv - FIFO-buffered AXI4-Stream master with fill/packet stats and overflow flag
//
// Purpose : accepts words from an internal producer (valid/ready), buffers
//           them in axis_sync_fifo and drives M_AXIS. Tracks sent packets and
//           a sticky overflow flag for producers that ignore TREADY_out.
// Config  : `define AXIS_MASTER_PKT_MODE_EN selects store-and-forward output
//           (TVALID held until a whole packet is stored, with a cut-through
//           escape when the FIFO fills without any complete packet).
//           Undefined: pure cut-through.
// Ports   : M_AXIS_ACLK, M_AXIS_ARESET (sync, active-high)
//           TDATA_in/TKEEP_in/TVALID_in/TLAST_in/TREADY_out - upstream side
//           M_AXIS_TDATA/TKEEP/TSTRB/TVALID/TLAST/TREADY    - stream side
//           fill_level - stored words; pkt_count - TLAST handshakes sent
//           overflow   - sticky, TVALID_in while not ready
//           clear_stats - synchronous clear of pkt_count and overflow
module axis_master_fifo
    import axis_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int PKT_CNT_WIDTH        = 16
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESET,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     TDATA_in,
    input  logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   TKEEP_in,
    input  logic                                TVALID_in,
    input  logic                                TLAST_in,
    output logic                                TREADY_out,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TVALID,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,
    output logic [ptr_w(FIFO_DEPTH)-1:0]        fill_level,
    output logic [PKT_CNT_WIDTH-1:0]            pkt_count,
    output logic                                overflow,
    input  logic                                clear_stats
);

    localparam int KW     = keep_w(C_M_AXIS_TDATA_WIDTH);
    localparam int PW     = ptr_w(FIFO_DEPTH);
    localparam int WORD_W = C_M_AXIS_TDATA_WIDTH + KW + 1;

    typedef struct packed {
        logic [C_M_AXIS_TDATA_WIDTH-1:0] data;
        logic [KW-1:0]                   keep;
        logic                            last;
    } beat_t;

    beat_t in_beat;
    beat_t out_beat;
    logic  fifo_valid;
    logic  gate;
    logic  push;
    logic  pop;

    always_comb begin
        in_beat.data = TDATA_in;
        in_beat.keep = TKEEP_in;
        in_beat.last = TLAST_in;
    end

    axis_sync_fifo #(
        .DATA_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (M_AXIS_ACLK),
        .rst        (M_AXIS_ARESET),
        .in_data    (in_beat),
        .in_valid   (TVALID_in),
        .in_ready   (TREADY_out),
        .out_data   (out_beat),
        .out_valid  (fifo_valid),
        .out_ready  (M_AXIS_TREADY && gate),
        .fill_level (fill_level)
    );

    assign push          = TVALID_in && TREADY_out;
    assign M_AXIS_TVALID = fifo_valid && gate;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    assign M_AXIS_TDATA  = out_beat.data;
    assign M_AXIS_TKEEP  = out_beat.keep;
    assign M_AXIS_TSTRB  = out_beat.keep;
    assign M_AXIS_TLAST  = out_beat.last;

`ifdef AXIS_MASTER_PKT_MODE_EN
    logic [PW-1:0] pkts_stored;
    logic          cut_through;
    logic          last_push;
    logic          last_pop;
    logic          stuck;

    assign last_push = push && TLAST_in;
    assign last_pop  = pop && out_beat.last;
    // Full with no TLAST inside can never complete a packet on its own, so
    // the head packet is let through until its TLAST leaves.
    assign stuck     = (fill_level == PW'(FIFO_DEPTH)) && (pkts_stored == '0);
    // All terms are registered, so TVALID never follows M_AXIS_TREADY.
    assign gate      = (pkts_stored != '0) || cut_through || stuck;

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            pkts_stored <= '0;
            cut_through <= 1'b0;
        end else begin
            if (last_push && !last_pop) begin
                pkts_stored <= pkts_stored + PW'(1);
            end else if (last_pop && !last_push) begin
                pkts_stored <= pkts_stored - PW'(1);
            end
            if (last_pop) begin
                cut_through <= 1'b0;
            end else if (stuck) begin
                cut_through <= 1'b1;
            end
        end
    end
`else
    assign gate = 1'b1;
`endif

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            pkt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop && out_beat.last) begin
                pkt_count <= clear_stats ? PKT_CNT_WIDTH'(1) : pkt_count + PKT_CNT_WIDTH'(1);
            end else if (clear_stats) begin
                pkt_count <= '0;
            end
            // A dropped word sets the flag even when a clear arrives with it.
            if (TVALID_in && !TREADY_out) begin
                overflow <= 1'b1;
            end else if (clear_stats) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_master_fifo.sv
// tb/tb_axis_master_fifo.sv - self-checking bench for axis_master_fifo
module tb_axis_master_fifo;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int PCW   = 16;

    logic            clk = 1'b0;
    logic            areset;
    logic [DW-1:0]   TDATA_in;
    logic [KW-1:0]   TKEEP_in;
    logic            TVALID_in;
    logic            TLAST_in;
    logic            TREADY_out;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic [KW-1:0]   M_AXIS_TKEEP;
    logic [KW-1:0]   M_AXIS_TSTRB;
    logic            M_AXIS_TVALID;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY;
    logic [$clog2(DEPTH):0] fill_level;
    logic [PCW-1:0]  pkt_count;
    logic            overflow;
    logic            clear_stats;

    axis_master_fifo #(
        .C_M_AXIS_TDATA_WIDTH (DW),
        .FIFO_DEPTH           (DEPTH),
        .PKT_CNT_WIDTH        (PCW)
    ) dut (
        .M_AXIS_ACLK   (clk),
        .M_AXIS_ARESET (areset),
        .TDATA_in      (TDATA_in),
        .TKEEP_in      (TKEEP_in),
        .TVALID_in     (TVALID_in),
        .TLAST_in      (TLAST_in),
        .TREADY_out    (TREADY_out),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .fill_level    (fill_level),
        .pkt_count     (pkt_count),
        .overflow      (overflow),
        .clear_stats   (clear_stats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    int n_pass  = 0;
    int n_total = 0;
    int pop_cnt = 0;
    bit mon_en  = 1'b0;
    bit rand_rdy = 1'b0;

    // Reference model state
    beat_t          q[$];
    logic [PCW-1:0] m_pkt;
    logic           m_ovf;
    logic           m_rel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Monitor: compares the DUT against the model away from the clock edge,
    // then advances the model by what the spec says happens at the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (areset) begin
                q.delete();
                m_pkt = '0;
                m_ovf = 1'b0;
                m_rel = 1'b0;
            end else begin
                bit    exp_ready, exp_valid, has_last, full_nolast, do_pop, do_push, popped_last;
                beat_t nb;
                exp_ready = (q.size() != DEPTH);
                has_last  = 1'b0;
                foreach (q[i]) if (q[i].last) has_last = 1'b1;
`ifdef AXIS_MASTER_PKT_MODE_EN
                exp_valid = (q.size() != 0) && (has_last || m_rel || q.size() == DEPTH);
`else
                exp_valid = (q.size() != 0);
`endif
                check("tready_out", 64'(TREADY_out), 64'(exp_ready));
                check("tvalid", 64'(M_AXIS_TVALID), 64'(exp_valid));
                check("fill_level", 64'(fill_level), 64'(q.size()));
                check("fill_max", 64'(fill_level <= DEPTH), 64'(1));
                check("pkt_count", 64'(pkt_count), 64'(m_pkt));
                check("overflow", 64'(overflow), 64'(m_ovf));
                if (exp_valid) begin
                    check("tdata", 64'(M_AXIS_TDATA), 64'(q[0].data));
                    check("tkeep", 64'(M_AXIS_TKEEP), 64'(q[0].keep));
                    check("tstrb", 64'(M_AXIS_TSTRB), 64'(q[0].keep));
                    check("tlast", 64'(M_AXIS_TLAST), 64'(q[0].last));
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) pop_cnt++;
                full_nolast = (q.size() == DEPTH) && !has_last;
                do_pop      = exp_valid && M_AXIS_TREADY;
                do_push     = TVALID_in && exp_ready;
                popped_last = 1'b0;
                if (do_pop) begin
                    popped_last = q[0].last;
                    void'(q.pop_front());
                end
                if (do_push) begin
                    nb.data = TDATA_in;
                    nb.keep = TKEEP_in;
                    nb.last = TLAST_in;
                    q.push_back(nb);
                end
                if (popped_last) m_pkt = clear_stats ? PCW'(1) : m_pkt + PCW'(1);
                else if (clear_stats) m_pkt = '0;
                if (TVALID_in && !exp_ready) m_ovf = 1'b1;
                else if (clear_stats) m_ovf = 1'b0;
                if (popped_last) m_rel = 1'b0;
                else if (full_nolast) m_rel = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) M_AXIS_TREADY = 1'($urandom_range(0, 1));
    endtask

    task automatic idle();
        TVALID_in = 1'b0;
        TLAST_in  = 1'b0;
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        bit acc;
        acc = 1'b0;
        TDATA_in  = d;
        TKEEP_in  = k;
        TLAST_in  = l;
        TVALID_in = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = TREADY_out;
            step();
        end
        check("send_accept", 64'(acc), 64'(1));
    endtask

    task automatic drain();
        idle();
        rand_rdy      = 1'b0;
        M_AXIS_TREADY = 1'b1;
        for (int i = 0; i < 300 && fill_level != 0; i++) step();
        step();
        check("drain_fill", 64'(fill_level), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        areset        = 1'b1;
        TDATA_in      = '0;
        TKEEP_in      = '0;
        TVALID_in     = 1'b0;
        TLAST_in      = 1'b0;
        M_AXIS_TREADY = 1'b0;
        clear_stats   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'(0));
        check("rst_tlast", 64'(M_AXIS_TLAST), 64'(0));
        check("rst_tdata", 64'(M_AXIS_TDATA), 64'(0));
        check("rst_tkeep", 64'(M_AXIS_TKEEP), 64'(0));
        check("rst_tstrb", 64'(M_AXIS_TSTRB), 64'(0));
        check("rst_fill", 64'(fill_level), 64'(0));
        check("rst_pkt", 64'(pkt_count), 64'(0));
        check("rst_ovf", 64'(overflow), 64'(0));
        check("rst_tready_out", 64'(TREADY_out), 64'(0));
        mon_en = 1'b1;
        step();
        areset = 1'b0;

        // 1: 32 words through an always-ready sink
        M_AXIS_TREADY = 1'b1;
        pop_cnt = 0;
        send(32'd0, 4'hF, 1'b0);
`ifndef AXIS_MASTER_PKT_MODE_EN
        check("t1_first_valid", 64'(M_AXIS_TVALID), 64'(1));
        check("t1_first_data", 64'(M_AXIS_TDATA), 64'(0));
`endif
        for (int i = 1; i < 32; i++) send(DW'(i), 4'hF, i == 31);
        drain();
        @(negedge clk);
        check("t1_pops", 64'(pop_cnt), 64'(32));
        check("t1_pkt", 64'(pkt_count), 64'(1));
        check("t1_ovf", 64'(overflow), 64'(0));

        // 2: blind producer into a stalled sink
        step();
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            TDATA_in  = DW'(i);
            TKEEP_in  = 4'hF;
            TLAST_in  = 1'b0;
            TVALID_in = 1'b1;
            step();
        end
        idle();
        @(negedge clk);
        check("t2_fill", 64'(fill_level), 64'(16));
        check("t2_tready_out", 64'(TREADY_out), 64'(0));
        check("t2_ovf", 64'(overflow), 64'(1));
        step();
        pop_cnt = 0;
        drain();
        @(negedge clk);
        check("t2_pops", 64'(pop_cnt), 64'(16));

        // 3: random sink ready, continuous producer, random data/keep/last
        step();
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send(DW'($urandom), KW'($urandom), (i == 999) || ($urandom_range(0, 7) == 0));
        end
        drain();

        // 4: reset mid-packet with five words stored
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) send(DW'(32'h400 + i), 4'hF, 1'b0);
        idle();
        @(negedge clk);
        check("t4_fill5", 64'(fill_level), 64'(5));
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        @(negedge clk);
        check("t4_tvalid", 64'(M_AXIS_TVALID), 64'(0));
        check("t4_fill", 64'(fill_level), 64'(0));
        check("t4_pkt", 64'(pkt_count), 64'(0));
        step();
        M_AXIS_TREADY = 1'b1;
        pop_cnt = 0;
        send(32'hA, 4'hF, 1'b0);
        send(32'hB, 4'h3, 1'b0);
        send(32'hC, 4'h1, 1'b1);
        drain();
        @(negedge clk);
        check("t4_pops", 64'(pop_cnt), 64'(3));

        // 5: clear_stats coincident with a TLAST pop at pkt_count=7
        step();
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        for (int i = 0; i < 7; i++) send(DW'(32'h500 + i), 4'hF, 1'b1);
        drain();
        @(negedge clk);
        check("t5_pkt7", 64'(pkt_count), 64'(7));
        step();
        M_AXIS_TREADY = 1'b0;
        send(32'h55, 4'hF, 1'b1);
        idle();
        step();
        clear_stats   = 1'b1;
        M_AXIS_TREADY = 1'b1;
        step();
        clear_stats = 1'b0;
        @(negedge clk);
        check("t5_pkt_clear_pop", 64'(pkt_count), 64'(1));
        drain();

`ifdef AXIS_MASTER_PKT_MODE_EN
        // 6: store-and-forward hold, then cut-through escape at full
        M_AXIS_TREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t6_hold", 64'(M_AXIS_TVALID), 64'(0));
            send(DW'(32'h600 + k), 4'hF, k == 3);
            if (k == 3) check("t6_release", 64'(M_AXIS_TVALID), 64'(1));
            idle();
            step();
            step();
        end
        drain();
        pop_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            send(DW'(32'h700 + i), 4'hF, 1'b0);
            if (i == 15) begin
                check("t6_full", 64'(fill_level), 64'(16));
                check("t6_cut", 64'(M_AXIS_TVALID), 64'(1));
            end
        end
        send(32'h7FF, 4'hF, 1'b1);
        drain();
        @(negedge clk);
        check("t6_pops", 64'(pop_cnt), 64'(21));
`endif

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
